// File: rtl/proc_pkg.sv
// proc_pkg: shared codes and widths for the sample sequencer
//   cmd_e    host command codes on proc_cmd
//   status_e codes reported on proc_status
//   state_e  sequencer FSM encoding
//   ACC_W    accumulator / constant width
package proc_pkg;
  localparam int ACC_W = 64;
  localparam int CNT_W = 32;
  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_START = 4'd1,
    CMD_ACK   = 4'd2,
    CMD_ABORT = 4'd3
  } cmd_e;
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_BUSY     = 4'd1,
    ST_COMPLETE = 4'd2,
    ST_ERROR    = 4'd3
  } status_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/proc_accum.sv
// proc_accum: sample / squared-sample accumulators and completed-iteration counter
//   clk, nRESET        clock, async active-low reset
//   clr                zero both accumulators and iter_cnt (wins over en)
//   en                 add sample/sample_sq and count one iteration
//   sample, sample_sq  engine results
//   sum, pow_sum       running sums, wrap modulo 2^64
//   iter_cnt           completed iterations
module proc_accum import proc_pkg::*; (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] sample,
  input  logic [ACC_W-1:0] sample_sq,
  output logic [ACC_W-1:0] sum,
  output logic [ACC_W-1:0] pow_sum,
  output logic [CNT_W-1:0] iter_cnt
);
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) begin
      sum      <= '0;
      pow_sum  <= '0;
      iter_cnt <= '0;
    end else if (clr) begin
      sum      <= '0;
      pow_sum  <= '0;
      iter_cnt <= '0;
    end else if (en) begin
      sum      <= sum + sample;
      pow_sum  <= pow_sum + sample_sq;
      iter_cnt <= iter_cnt + 1'b1;
    end
endmodule

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: host-commanded sequencer issuing one engine request per iteration
//   TIMEOUT_CYCLES     max wait for eng_ack (only with PROC_TIMEOUT_EN defined)
//   clk, nRESET        clock, async active-low reset
//   proc_cmd           host command level (edge-detected against cmd_q)
//   niter, constK/1/2  run parameters, latched on START
//   eng_load           one-cycle reload pulse, eng_constK/1/2 latched constants
//   eng_req/eng_ack    sample handshake, eng_sample/eng_sample_sq results
//   proc_status        0 IDLE, 1 BUSY, 2 COMPLETE, 3 ERROR
//   proc_sum_dout, proc_pow_sum_dout, iter_cnt  run results
// Build option: PROC_TIMEOUT_EN adds the eng_ack wait timeout leading to ERROR.
module proc_seq_ctrl import proc_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic [3:0]       proc_cmd,
  input  logic [CNT_W-1:0] niter,
  input  logic [ACC_W-1:0] constK,
  input  logic [ACC_W-1:0] const1,
  input  logic [ACC_W-1:0] const2,
  output logic             eng_load,
  output logic [ACC_W-1:0] eng_constK,
  output logic [ACC_W-1:0] eng_const1,
  output logic [ACC_W-1:0] eng_const2,
  output logic             eng_req,
  input  logic             eng_ack,
  input  logic [ACC_W-1:0] eng_sample,
  input  logic [ACC_W-1:0] eng_sample_sq,
  output logic [3:0]       proc_status,
  output logic [ACC_W-1:0] proc_sum_dout,
  output logic [ACC_W-1:0] proc_pow_sum_dout,
  output logic [CNT_W-1:0] iter_cnt
);
  state_e           state;
  logic [3:0]       cmd_q;
  logic [CNT_W-1:0] niter_q;
  logic             new_cmd, start, ack, abort, acc_clr, acc_en, last, timeout;
  // Commands act only on the cycle the level changes, so a held level never retriggers.
  assign new_cmd = proc_cmd != cmd_q;
  assign start   = new_cmd && proc_cmd == CMD_START;
  assign ack     = new_cmd && proc_cmd == CMD_ACK;
  assign abort   = new_cmd && proc_cmd == CMD_ABORT;
  // Clearing on the START edge makes zeroed results visible during the LOAD cycle.
  assign acc_clr = state == S_IDLE && start;
  // An ack coinciding with ABORT is dropped.
  assign acc_en  = state == S_REQ && eng_ack && !abort;
  assign last    = iter_cnt + 1'b1 == niter_q;
`ifdef PROC_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  // Counts REQ cycles since the last ack; outside REQ it sits at zero so entry starts fresh.
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) wait_cnt <= '0;
    else wait_cnt <= (state != S_REQ || eng_ack) ? '0 : wait_cnt + 1'b1;
  // A late ack in the final cycle still wins because timeout is gated by !eng_ack.
  assign timeout = !eng_ack && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      niter_q     <= '0;
      eng_load    <= 1'b0;
      eng_req     <= 1'b0;
      eng_constK  <= '0;
      eng_const1  <= '0;
      eng_const2  <= '0;
      proc_status <= ST_IDLE;
    end else begin
      cmd_q    <= proc_cmd;
      eng_load <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            state       <= S_LOAD;
            eng_load    <= 1'b1;
            niter_q     <= niter;
            eng_constK  <= constK;
            eng_const1  <= const1;
            eng_const2  <= const2;
            proc_status <= ST_BUSY;
          end
        S_LOAD:
          if (abort) begin
            state       <= S_IDLE;
            proc_status <= ST_IDLE;
          end else if (niter_q == '0) begin
            state       <= S_DONE;
            proc_status <= ST_COMPLETE;
          end else begin
            state   <= S_REQ;
            eng_req <= 1'b1;
          end
        S_REQ:
          if (abort) begin
            state       <= S_IDLE;
            eng_req     <= 1'b0;
            proc_status <= ST_IDLE;
          end else if (eng_ack && last) begin
            state       <= S_DONE;
            eng_req     <= 1'b0;
            proc_status <= ST_COMPLETE;
          end else if (timeout) begin
            state       <= S_ERR;
            eng_req     <= 1'b0;
            proc_status <= ST_ERROR;
          end
        S_DONE, S_ERR:
          if (ack) begin
            state       <= S_IDLE;
            proc_status <= ST_IDLE;
          end
        default: begin
          state       <= S_IDLE;
          eng_req     <= 1'b0;
          proc_status <= ST_IDLE;
        end
      endcase
    end
  proc_accum u_accum (
    .clk       (clk),
    .nRESET    (nRESET),
    .clr       (acc_clr),
    .en        (acc_en),
    .sample    (eng_sample),
    .sample_sq (eng_sample_sq),
    .sum       (proc_sum_dout),
    .pow_sum   (proc_pow_sum_dout),
    .iter_cnt  (iter_cnt)
  );
endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb_proc_seq_ctrl: directed self-checking bench for proc_seq_ctrl
module tb_proc_seq_ctrl;
  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic [3:0]  proc_cmd = 4'd0;
  logic [31:0] niter = '0;
  logic [63:0] constK = '0, const1 = '0, const2 = '0;
  logic        eng_load, eng_req;
  logic [63:0] eng_constK, eng_const1, eng_const2;
  logic        eng_ack = 1'b0;
  logic [63:0] eng_sample = '0, eng_sample_sq = '0;
  logic [3:0]  proc_status;
  logic [63:0] proc_sum_dout, proc_pow_sum_dout;
  logic [31:0] iter_cnt;
  int errs = 0, checks = 0;
  int n_load = 0, n_req = 0, load0, req0;
  proc_seq_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .nRESET            (nRESET),
    .proc_cmd          (proc_cmd),
    .niter             (niter),
    .constK            (constK),
    .const1            (const1),
    .const2            (const2),
    .eng_load          (eng_load),
    .eng_constK        (eng_constK),
    .eng_const1        (eng_const1),
    .eng_const2        (eng_const2),
    .eng_req           (eng_req),
    .eng_ack           (eng_ack),
    .eng_sample        (eng_sample),
    .eng_sample_sq     (eng_sample_sq),
    .proc_status       (proc_status),
    .proc_sum_dout     (proc_sum_dout),
    .proc_pow_sum_dout (proc_pow_sum_dout),
    .iter_cnt          (iter_cnt)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (eng_load) n_load++;
    if (eng_req) n_req++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic host(input logic [3:0] c);
    proc_cmd = c;
    step();
    proc_cmd = 4'd0;
  endtask
  task automatic beat(input logic [63:0] s, input logic [63:0] sq);
    eng_ack = 1'b1;
    eng_sample = s;
    eng_sample_sq = sq;
    step();
    eng_ack = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_status", proc_status, 0);
    chk("rst_req", eng_req, 0);
    chk("rst_load", eng_load, 0);
    chk("rst_sum", proc_sum_dout, 0);
    chk("rst_pow", proc_pow_sum_dout, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_constK", eng_constK, 0);
    nRESET = 1'b1;
    step();
    // normal run
    constK = 64'h1111; const1 = 64'h2222; const2 = 64'h3333; niter = 4;
    load0 = n_load;
    host(4'd1);
    chk("run_load", eng_load, 1);
    chk("run_busy", proc_status, 1);
    chk("run_req_in_load", eng_req, 0);
    chk("run_constK", eng_constK, 64'h1111);
    chk("run_const2", eng_const2, 64'h3333);
    step();
    chk("run_req", eng_req, 1);
    chk("run_load_pulse", eng_load, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) constK = 64'hDEAD;
      beat(64'(i), 64'(i * i));
    end
    chk("run_status", proc_status, 2);
    chk("run_req_off", eng_req, 0);
    chk("run_sum", proc_sum_dout, 10);
    chk("run_pow", proc_pow_sum_dout, 30);
    chk("run_iter", iter_cnt, 4);
    chk("run_constK_held", eng_constK, 64'h1111);
    chk("run_one_load", 64'(n_load - load0), 1);
    host(4'd2);
    chk("run_ack_idle", proc_status, 0);
    // zero iterations
    niter = 0;
    load0 = n_load;
    req0 = n_req;
    host(4'd1);
    chk("zero_load", eng_load, 1);
    step();
    chk("zero_status", proc_status, 2);
    chk("zero_sum", proc_sum_dout, 0);
    chk("zero_iter", iter_cnt, 0);
    step(3);
    chk("zero_loads", 64'(n_load - load0), 1);
    chk("zero_reqs", 64'(n_req - req0), 0);
    host(4'd2);
    chk("zero_idle", proc_status, 0);
    // wrap-around
    niter = 2;
    host(4'd1);
    step();
    beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("wrap_mid_status", proc_status, 1);
    beat(64'd2, 64'd4);
    chk("wrap_sum", proc_sum_dout, 1);
    chk("wrap_pow", proc_pow_sum_dout, 5);
    chk("wrap_status", proc_status, 2);
    host(4'd2);
    // abort with a coincident ack
    niter = 100;
    host(4'd1);
    step();
    beat(64'd5, 64'd25);
    beat(64'd6, 64'd36);
    beat(64'd7, 64'd49);
    eng_ack = 1'b1;
    eng_sample = 64'd8;
    eng_sample_sq = 64'd64;
    host(4'd3);
    eng_ack = 1'b0;
    chk("abort_status", proc_status, 0);
    chk("abort_req", eng_req, 0);
    chk("abort_iter", iter_cnt, 3);
    chk("abort_sum", proc_sum_dout, 18);
    chk("abort_pow", proc_pow_sum_dout, 110);
    niter = 1;
    host(4'd1);
    chk("restart_sum_clr", proc_sum_dout, 0);
    chk("restart_iter_clr", iter_cnt, 0);
    step();
    beat(64'd9, 64'd81);
    chk("restart_sum", proc_sum_dout, 9);
    chk("restart_status", proc_status, 2);
    host(4'd2);
    // held START runs exactly once
    niter = 1;
    load0 = n_load;
    proc_cmd = 4'd1;
    step(2);
    beat(64'd3, 64'd9);
    chk("held_done", proc_status, 2);
    step(50);
    chk("held_still_done", proc_status, 2);
    chk("held_one_load", 64'(n_load - load0), 1);
    proc_cmd = 4'd2;
    step();
    chk("held_ack_idle", proc_status, 0);
    step(5);
    chk("held_ack_stays", proc_status, 0);
    chk("held_no_rerun", 64'(n_load - load0), 1);
    proc_cmd = 4'd0;
    step();
`ifdef PROC_TIMEOUT_EN
    niter = 5;
    host(4'd1);
    step();
    step(7);
    chk("to_waiting", proc_status, 1);
    chk("to_req_waiting", eng_req, 1);
    step();
    chk("to_error", proc_status, 3);
    chk("to_req_off", eng_req, 0);
    host(4'd2);
    chk("to_ack_idle", proc_status, 0);
`else
    niter = 5;
    host(4'd1);
    step(40);
    chk("nto_busy", proc_status, 1);
    chk("nto_req", eng_req, 1);
    host(4'd3);
    chk("nto_abort", proc_status, 0);
`endif
    // asynchronous reset mid-run
    niter = 10;
    host(4'd1);
    step();
    beat(64'd4, 64'd16);
    chk("mid_req_before", eng_req, 1);
    #3 nRESET = 1'b0;
    #1;
    chk("mid_rst_req", eng_req, 0);
    chk("mid_rst_status", proc_status, 0);
    chk("mid_rst_sum", proc_sum_dout, 0);
    chk("mid_rst_iter", iter_cnt, 0);
    step();
    nRESET = 1'b1;
    step(2);
    chk("mid_rst_idle", proc_status, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
